cordic_iter_ctrl: RTL

CORDIC_ITER_CTRL -- requirements
Module: cordic_iter_ctrl

---
 rtl/cordic_pkg.sv | 38 +++
 rtl/cordic_iter_stage.sv | 32 +++
 rtl/cordic_iter_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: default width, controller states and Q2.13 angle tables.
package cordic_pkg;

    localparam int N_DEFAULT = 16;
    localparam int TABLE_LEN = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // round(atan(2^-j) * 8192)
    localparam logic signed [15:0] ARCTAN [0:TABLE_LEN-1] = '{
        16'sd6434, 16'sd3798, 16'sd2007, 16'sd1019,
        16'sd511,  16'sd256,  16'sd128,  16'sd64,
        16'sd32,   16'sd16,   16'sd8,    16'sd4,
        16'sd2,    16'sd1,    16'sd0,    16'sd0
    };

    // round(atanh(2^-j) * 8192); entry 0 is unbounded and never used
    localparam logic signed [15:0] ARCTANH [0:TABLE_LEN-1] = '{
        16'sd0,    16'sd4500, 16'sd2092, 16'sd1029,
        16'sd513,  16'sd256,  16'sd128,  16'sd64,
        16'sd32,   16'sd16,   16'sd8,    16'sd4,
        16'sd2,    16'sd1,    16'sd1,    16'sd0
    };

    function automatic logic signed [15:0] alpha_lookup(input logic m, input int j);
        logic signed [15:0] a;
        a = 16'sd0;
        if (j >= 0 && j < TABLE_LEN) begin
            a = m ? ARCTAN[j] : ARCTANH[j];
        end
        return a;
    endfunction

endpackage

// File: rtl/cordic_iter_stage.sv
// One combinational CORDIC micro-rotation with a runtime shift amount.
module cordic_iter_stage #(
    parameter int N  = 16,
    parameter int JW = 4
) (
    input  logic [JW-1:0]       shift,
    input  logic                m,
    input  logic                rot_vec,
    input  logic signed [N-1:0] x,
    input  logic signed [N-1:0] y,
    input  logic signed [N-1:0] z,
    input  logic signed [N-1:0] alpha,
    output logic signed [N-1:0] x_next,
    output logic signed [N-1:0] y_next,
    output logic signed [N-1:0] z_next
);

    logic                sigma;
    logic signed [N-1:0] x_sh;
    logic signed [N-1:0] y_sh;

    // Arithmetic shifts fill with the sign once the shift reaches the width.
    always_comb begin
        sigma  = rot_vec ? ~z[N-1] : y[N-1];
        x_sh   = x >>> shift;
        y_sh   = y >>> shift;
        x_next = (m ^ sigma) ? (x + y_sh) : (x - y_sh);
        y_next = sigma ? (y + x_sh) : (y - x_sh);
        z_next = sigma ? (z - alpha) : (z + alpha);
    end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC controller: one micro-rotation per RUN cycle, circular or hyperbolic.
module cordic_iter_ctrl
    import cordic_pkg::*;
#(
    parameter int N    = N_DEFAULT,
    parameter int ITER = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_m,
    input  logic                in_rot_vec,
    input  logic signed [N-1:0] in_x,
    input  logic signed [N-1:0] in_y,
    input  logic signed [N-1:0] in_z,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] out_x,
    output logic signed [N-1:0] out_y,
    output logic signed [N-1:0] out_z,
    output logic                busy
);

    localparam int JW = $clog2(N);

    state_t              state;
    state_t              state_next;
    logic [JW-1:0]       j;
    logic                rep;
    logic                m_r;
    logic                rv_r;
    logic signed [N-1:0] x_r;
    logic signed [N-1:0] y_r;
    logic signed [N-1:0] z_r;
    logic signed [N-1:0] x_n;
    logic signed [N-1:0] y_n;
    logic signed [N-1:0] z_n;
    logic signed [15:0]  alpha16;
    logic signed [N-1:0] alpha;
    int                  j_int;
    logic                need_rep;
    logic                last_step;

    assign j_int   = int'(j);
    assign alpha16 = alpha_lookup(m_r, j_int);
    assign alpha   = N'(alpha16);

    // Hyperbolic mode revisits shifts 4 and 13 once each to keep convergence.
    assign need_rep  = !m_r && (j_int == 4 || j_int == 13) && !rep;
    assign last_step = m_r ? (j_int == ITER - 1) : (j_int == ITER && !need_rep);

    cordic_iter_stage #(
        .N  (N),
        .JW (JW)
    ) u_stage (
        .shift   (j),
        .m       (m_r),
        .rot_vec (rv_r),
        .x       (x_r),
        .y       (y_r),
        .z       (z_r),
        .alpha   (alpha),
        .x_next  (x_n),
        .y_next  (y_n),
        .z_next  (z_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_r  <= 1'b0;
            rv_r <= 1'b0;
            x_r  <= '0;
            y_r  <= '0;
            z_r  <= '0;
            j    <= '0;
            rep  <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            m_r  <= in_m;
            rv_r <= in_rot_vec;
            x_r  <= in_x;
            y_r  <= in_y;
            z_r  <= in_z;
            j    <= in_m ? JW'(0) : JW'(1);
            rep  <= 1'b0;
        end else if (state == RUN) begin
            x_r <= x_n;
            y_r <= y_n;
            z_r <= z_n;
            if (need_rep) begin
                rep <= 1'b1;
            end else begin
                rep <= 1'b0;
                j   <= j + 1'b1;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_x     = x_r;
    assign out_y     = y_r;
    assign out_z     = z_r;

endmodule
